// File: rtl/light_timer_sequencer.sv
// Phase timing core for the traffic light controller: programmable durations,
// a seconds divider and a per-phase countdown with a one-cycle Expired pulse.
`timescale 1ns/1ps

module light_timer_sequencer #(
    parameter int CLK_DIV    = 100000,
    parameter int T_BASE_DEF = 6,
    parameter int T_EXT_DEF  = 3,
    parameter int T_YEL_DEF  = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Reprogram,
    input  logic [1:0] Selector,
    input  logic [3:0] Time_Value,
    input  logic [1:0] Interval,
    input  logic       Start_Timer,
    output logic [3:0] Value,
    output logic [3:0] Remaining,
    output logic       Busy,
    output logic       OneHz,
    output logic       Expired
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           r_state;
    logic [3:0]       r_t_base;
    logic [3:0]       r_t_ext;
    logic [3:0]       r_t_yel;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_remaining;
    logic             r_one_hz;
    logic             r_expired;

    logic [3:0]       w_value;
    logic [3:0]       w_wr_val;
    logic             w_tick;

    always_comb begin
        w_value = r_t_base;
        case (Interval)
            2'b01:   w_value = r_t_ext;
            2'b10:   w_value = r_t_yel;
            default: w_value = r_t_base;
        endcase
    end

    // A zero duration would never expire, so it is stored as one second.
    assign w_wr_val = (Time_Value == 4'd0) ? 4'd1 : Time_Value;
    assign w_tick   = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_t_base <= 4'(T_BASE_DEF);
            r_t_ext  <= 4'(T_EXT_DEF);
            r_t_yel  <= 4'(T_YEL_DEF);
        end else if (Reprogram) begin
            case (Selector)
                2'b00:   r_t_base <= w_wr_val;
                2'b01:   r_t_ext  <= w_wr_val;
                2'b10:   r_t_yel  <= w_wr_val;
                default: ;
            endcase
        end
    end

    // Reprogram outranks Start_Timer, and both resynchronise the divider so a
    // started interval spans exactly Value*CLK_DIV cycles.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_remaining <= 4'd0;
            r_one_hz    <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_one_hz  <= 1'b0;
            r_expired <= 1'b0;
            if (Reprogram) begin
                r_state     <= IDLE;
                r_div       <= '0;
                r_remaining <= 4'd0;
            end else if (Start_Timer) begin
                r_state     <= COUNT;
                r_div       <= '0;
                r_remaining <= w_value;
            end else begin
                if (w_tick) begin
                    r_div    <= '0;
                    r_one_hz <= 1'b1;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
                if (r_state == COUNT && w_tick) begin
                    if (r_remaining <= 4'd1) begin
                        r_remaining <= 4'd0;
                        r_expired   <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_remaining <= r_remaining - 4'd1;
                    end
                end
            end
        end
    end

    assign Value     = w_value;
    assign Remaining = r_remaining;
    assign Busy      = (r_state == COUNT);
    assign OneHz     = r_one_hz;
    assign Expired   = r_expired;

endmodule

// File: tb/tb_light_timer_sequencer.sv
// Bench for light_timer_sequencer: cycle-budget model compared every cycle,
// directed timing scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps

module tb_light_timer_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Reprogram = 1'b0;
    logic [1:0] Selector = 2'b00;
    logic [3:0] Time_Value = 4'd0;
    logic [1:0] Interval = 2'b00;
    logic       Start_Timer = 1'b0;
    logic [3:0] Value;
    logic [3:0] Remaining;
    logic       Busy;
    logic       OneHz;
    logic       Expired;

    int vectors = 0;
    int miscompares = 0;

    light_timer_sequencer #(.CLK_DIV(DIV)) dut (
        .clk(clk), .Reset(Reset), .Reprogram(Reprogram), .Selector(Selector),
        .Time_Value(Time_Value), .Interval(Interval), .Start_Timer(Start_Timer),
        .Value(Value), .Remaining(Remaining), .Busy(Busy), .OneHz(OneHz),
        .Expired(Expired)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: durations, cycles since the last divider sync, and cycles left
    // in the running interval. Remaining is the ceiling of cycles left / DIV.
    int m_par[3] = '{6, 3, 2};
    int m_ph = 0;
    int m_left = 0;
    bit m_busy = 1'b0;
    bit m_hz = 1'b0;
    bit m_exp = 1'b0;

    function automatic int m_value(input logic [1:0] iv);
        return (iv == 2'b11) ? m_par[0] : m_par[iv];
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_par = '{6, 3, 2};
            m_ph = 0; m_left = 0; m_busy = 1'b0; m_hz = 1'b0; m_exp = 1'b0;
        end else begin
            m_hz = 1'b0;
            m_exp = 1'b0;
            if (Reprogram) begin
                if (Selector != 2'b11)
                    m_par[Selector] = (Time_Value == 4'd0) ? 1 : int'(Time_Value);
                m_ph = 0; m_busy = 1'b0; m_left = 0;
            end else if (Start_Timer) begin
                m_ph = 0; m_busy = 1'b1; m_left = m_value(Interval) * DIV;
            end else begin
                m_ph = (m_ph + 1) % DIV;
                if (m_ph == 0) m_hz = 1'b1;
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_exp = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!Reset) begin
            chk("value", int'(Value), m_value(Interval));
            chk("remaining", int'(Remaining), (m_left + DIV - 1) / DIV);
            chk("busy", int'(Busy), int'(m_busy));
            chk("onehz", int'(OneHz), int'(m_hz));
            chk("expired", int'(Expired), int'(m_exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_par(input logic [1:0] sel, input logic [3:0] val);
        Reprogram = 1'b1; Selector = sel; Time_Value = val;
        tick();
        Reprogram = 1'b0;
    endtask

    task automatic start_pulse();
        Start_Timer = 1'b1;
        tick();
        Start_Timer = 1'b0;
    endtask

    // k counts negedges after start edge S (k=0 is just after S). A restart
    // is sampled on edge S+restart_at when restart_at > 0.
    task automatic measure(input int restart_at, input int reload_exp,
                           output int first_k, output int n_exp, output int n_hz);
        first_k = -1; n_exp = 0; n_hz = 0;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            if (restart_at > 0 && k == restart_at - 1) Start_Timer = 1'b1;
            if (restart_at > 0 && k == restart_at) begin
                Start_Timer = 1'b0;
                chk("restart_reload", int'(Remaining), reload_exp);
            end
            if (Expired) begin
                n_exp++;
                if (first_k < 0) first_k = k;
            end
            if (OneHz && k <= 24) n_hz++;
        end
        #1;
    endtask

    task automatic check_values(input int v0, input int v1, input int v2, input string tag);
        Interval = 2'b00; #1 chk({tag, "_val00"}, int'(Value), v0);
        Interval = 2'b01; #1 chk({tag, "_val01"}, int'(Value), v1);
        Interval = 2'b10; #1 chk({tag, "_val10"}, int'(Value), v2);
        Interval = 2'b11; #1 chk({tag, "_val11"}, int'(Value), v0);
    endtask

    initial begin
        int fk, ne, nh;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;

        chk("reset_busy", int'(Busy), 0);
        chk("reset_remaining", int'(Remaining), 0);
        chk("reset_expired", int'(Expired), 0);
        check_values(6, 3, 2, "reset");
        tick();

        // Default tBase run
        Interval = 2'b00;
        start_pulse();
        chk("start_busy", int'(Busy), 1);
        chk("start_remaining", int'(Remaining), 6);
        measure(0, 0, fk, ne, nh);
        chk("default_expire_k", fk, 24);
        chk("default_expire_count", ne, 1);
        chk("default_onehz_count", nh, 6);
        chk("default_busy_after", int'(Busy), 0);

        // Reprogram tExt to 9
        write_par(2'b01, 4'd9);
        Interval = 2'b01; #1 chk("reprog_value", int'(Value), 9);
        start_pulse();
        measure(0, 0, fk, ne, nh);
        chk("reprog_expire_k", fk, 36);
        write_par(2'b11, 4'd5);
        check_values(6, 9, 2, "sel11");

        // Zero clamp on tYel
        write_par(2'b10, 4'd0);
        Interval = 2'b10; #1 chk("clamp_value", int'(Value), 1);
        start_pulse();
        measure(0, 0, fk, ne, nh);
        chk("clamp_expire_k", fk, 4);
        chk("clamp_expire_count", ne, 1);

        // Restart mid-interval and on the final tick
        Interval = 2'b00;
        start_pulse();
        measure(10, 6, fk, ne, nh);
        chk("restart_expire_k", fk, 34);
        chk("restart_expire_count", ne, 1);
        start_pulse();
        measure(24, 6, fk, ne, nh);
        chk("finaltick_expire_k", fk, 48);
        chk("finaltick_expire_count", ne, 1);

        // Reprogram with simultaneous start aborts
        start_pulse();
        repeat (7) tick();
        Reprogram = 1'b1; Selector = 2'b11; Start_Timer = 1'b1;
        tick();
        Reprogram = 1'b0; Start_Timer = 1'b0;
        chk("abort_busy", int'(Busy), 0);
        chk("abort_remaining", int'(Remaining), 0);
        ne = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Expired) ne++;
        end
        #1 chk("abort_no_expire", ne, 0);

        // Asynchronous reset mid-count
        write_par(2'b00, 4'd11);
        Interval = 2'b00;
        start_pulse();
        repeat (5) tick();
        @(negedge clk);
        #1 Reset = 1'b1;
        #1;
        chk("areset_busy", int'(Busy), 0);
        chk("areset_remaining", int'(Remaining), 0);
        chk("areset_onehz", int'(OneHz), 0);
        chk("areset_expired", int'(Expired), 0);
        check_values(6, 3, 2, "areset");
        @(negedge clk);
        #1 Reset = 1'b0;
        tick();

        // Random traffic against the model
        repeat (600) begin
            Reprogram   = ($urandom_range(0, 15) == 0);
            Start_Timer = ($urandom_range(0, 9) == 0);
            Selector    = 2'($urandom_range(0, 3));
            Time_Value  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) Interval = 2'($urandom_range(0, 3));
            tick();
        end
        Reprogram = 1'b0; Start_Timer = 1'b0;
        repeat (80) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
